// File: rtl/frame_write_scheduler_pkg.sv
// Shared definitions for the frame-buffer write scheduler: source IDs,
// select width and the sequencing state type.
package frame_write_scheduler_pkg;

  localparam int FWS_SEL_ADDRW = 2;

  localparam logic [FWS_SEL_ADDRW-1:0] SRC_BKG      = 2'd0;
  localparam logic [FWS_SEL_ADDRW-1:0] SRC_SPRITE_A = 2'd1;
  localparam logic [FWS_SEL_ADDRW-1:0] SRC_SPRITE_B = 2'd2;
  localparam logic [FWS_SEL_ADDRW-1:0] SRC_OVERLAY  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    ACTIVE,
    SETTLE,
    ADVANCE,
    DONE
  } fws_state_e;

endpackage

// File: rtl/frame_write_scheduler_next_source_finder.sv
// Picks the lowest enabled source ID above the current one, or the lowest
// enabled ID overall when a frame is just starting.
module frame_write_scheduler_next_source_finder #(
  parameter int NUM_SOURCES = 4,
  parameter int SEL_W       = 2
)(
  input  logic [NUM_SOURCES-1:0] en,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   from_start,
  output logic                   found,
  output logic [SEL_W-1:0]       next_id
);

  // Scan downward so the lowest qualifying ID is the last one written.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (en[i] && (from_start || (SEL_W'(i) > sel))) begin
        found   = 1'b1;
        next_id = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Walks the enabled write sources in ascending ID order once per frame,
// strobing each and tracking its write_active burst or start timeout.
module frame_write_scheduler
  import frame_write_scheduler_pkg::*;
#(
  parameter int NUM_SOURCES      = 4,
  parameter int SOURCE_SEL_ADDRW = FWS_SEL_ADDRW,
  parameter int START_TIMEOUT    = 8,
  parameter int FRAME_CNT_W      = 16
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic [NUM_SOURCES-1:0]      source_enable,
  input  logic                        write_active,
  output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  output logic                        write_awaited,
  output logic                        busy,
  output logic                        frame_done,
  output logic [NUM_SOURCES-1:0]      skip_mask,
  output logic                        frame_overrun,
  output logic [FRAME_CNT_W-1:0]      frame_count
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  fws_state_e                  state_q, state_d;
  logic [NUM_SOURCES-1:0]      en_q, en_d;
  logic [NUM_SOURCES-1:0]      skip_q, skip_d;
  logic                        pending_q, pending_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
  logic                        awaited_q, awaited_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        overrun_q, overrun_d;
  logic [FRAME_CNT_W-1:0]      count_q, count_d;

  logic                        active;
  logic                        nxt_found;
  logic [SOURCE_SEL_ADDRW-1:0] nxt_id;

  // A floating or unknown bus reads as idle.
  assign active = (write_active === 1'b1);

  frame_write_scheduler_next_source_finder #(
    .NUM_SOURCES (NUM_SOURCES),
    .SEL_W       (SOURCE_SEL_ADDRW)
  ) u_finder (
    .en         ((state_q == IDLE) ? source_enable : en_q),
    .sel        (sel_q),
    .from_start (state_q == IDLE),
    .found      (nxt_found),
    .next_id    (nxt_id)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    skip_d    = skip_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start || pending_q) begin
          en_d      = source_enable;
          skip_d    = '0;
          // A new request arriving while a queued frame is accepted re-queues.
          pending_d = pending_q && frame_start;
          if (nxt_found) begin
            sel_d   = nxt_id;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (active) begin
          state_d = ACTIVE;
        end else if (cnt_q == CNT_LAST) begin
          skip_d[sel_q] = 1'b1;
          state_d       = ADVANCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE:  if (!active) state_d = SETTLE;
      SETTLE:  state_d = ADVANCE;
      ADVANCE: begin
        if (nxt_found) begin
          sel_d   = nxt_id;
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && frame_start) begin
      if (!pending_q) pending_d = 1'b1;
      else            overrun_d = 1'b1;
    end

    awaited_d = (state_d == ISSUE);
    done_d    = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    count_d   = (state_d == DONE) ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      en_q      <= '0;
      skip_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= '0;
      awaited_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      skip_q    <= skip_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      awaited_q <= awaited_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign skip_mask        = skip_q;
  assign frame_overrun    = overrun_q;
  assign frame_count      = count_q;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Scoreboard bench: stimulus queues expected strobe/done/overrun events,
// a negedge monitor pops and compares them as the scheduler emits them.
module tb_frame_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  source_enable;
  logic        write_active;
  logic [1:0]  write_source_sel;
  logic        write_awaited;
  logic        busy;
  logic        frame_done;
  logic [3:0]  skip_mask;
  logic        frame_overrun;
  logic [15:0] frame_count;

  frame_write_scheduler #(
    .NUM_SOURCES(4), .SOURCE_SEL_ADDRW(2), .START_TIMEOUT(8), .FRAME_CNT_W(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .source_enable    (source_enable),
    .write_active     (write_active),
    .write_source_sel (write_source_sel),
    .write_awaited    (write_awaited),
    .busy             (busy),
    .frame_done       (frame_done),
    .skip_mask        (skip_mask),
    .frame_overrun    (frame_overrun),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_AWAIT = 0, EV_DONE = 1, EV_OVR = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       sel;
    int       skip;
    int       count;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0;
  int  burst_len[4];
  int  await_cnt = 0, done_cnt = 0;
  int  last_await_cyc = 0, last_fall_cyc = 0, last_done_cyc = 0;
  int  cur_sel = 0;
  int  exp_count = 0;
  int  start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input int sel, input int skip, input int count);
    ev_t e;
    e.kind = k; e.sel = sel; e.skip = skip; e.count = count;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input ev_kind_e k, input int sel, input int skip, input int count);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", int'(k));
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k == EV_AWAIT) chk("await_sel", sel, e.sel);
    if (k == EV_DONE) begin
      chk("done_skip_mask", skip, e.skip);
      chk("done_frame_count", count, e.count);
    end
  endtask

  // Monitor
  initial begin
    logic prev_awaited, prev_active;
    prev_awaited = 1'b0; prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write_awaited) begin
          chk("awaited_not_back_to_back", int'(prev_awaited), 0);
          pop_chk(EV_AWAIT, int'(write_source_sel), 0, 0);
          cur_sel = int'(write_source_sel);
          last_await_cyc = cyc;
          await_cnt++;
        end
        if (write_active === 1'b1) chk("sel_stable_in_burst", int'(write_source_sel), cur_sel);
        if (prev_active && write_active !== 1'b1) last_fall_cyc = cyc;
        if (frame_overrun) pop_chk(EV_OVR, 0, 0, 0);
        if (frame_done) begin
          pop_chk(EV_DONE, 0, int'(skip_mask), int'(frame_count));
          last_done_cyc = cyc;
          done_cnt++;
        end
      end
      prev_awaited = write_awaited;
      prev_active  = (write_active === 1'b1);
    end
  end

  // Source model: after a strobe, raise write_active 2 edges later for the
  // configured burst length; a zero length never responds.
  initial begin
    int l;
    write_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && write_awaited) begin
        l = burst_len[write_source_sel];
        if (l > 0) begin
          repeat (2) @(posedge clk);
          #1 write_active = 1'b1;
          repeat (l) @(posedge clk);
          #1 write_active = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string name);
    int t;
    t = 0;
    while (done_cnt < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk(name, done_cnt, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},      int'(write_source_sel), 0);
    chk({tag, "_awaited"},  int'(write_awaited), 0);
    chk({tag, "_busy"},     int'(busy), 0);
    chk({tag, "_done"},     int'(frame_done), 0);
    chk({tag, "_skip"},     int'(skip_mask), 0);
    chk({tag, "_overrun"},  int'(frame_overrun), 0);
    chk({tag, "_count"},    int'(frame_count), 0);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; source_enable = 4'b0000;
    burst_len = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single source
    burst_len = '{10, 0, 0, 0};
    source_enable = 4'b0001;
    push(EV_AWAIT, 0, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    pulse_start();
    chk("t1_busy_after_accept", int'(busy), 1);
    wait_done(1, "t1_frame_done");
    chk("t1_start_latency", last_await_cyc - start_cyc, 1);
    chk("t1_done_after_fall", last_done_cyc - last_fall_cyc, 3);
    chk("t1_await_pulses", await_cnt, 1);
    chk("t1_busy_dropped", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Ordering, enable change mid-frame ignored
    burst_len = '{5, 5, 5, 5};
    source_enable = 4'b1011;
    push(EV_AWAIT, 0, 0, 0); push(EV_AWAIT, 1, 0, 0); push(EV_AWAIT, 3, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    pulse_start();
    source_enable = 4'b1111;
    wait_done(2, "t2_frame_done");
    chk("t2_await_pulses", await_cnt, 4);
    repeat (3) @(negedge clk);

    // Timeout on source 2
    burst_len = '{5, 5, 0, 5};
    source_enable = 4'b0110;
    push(EV_AWAIT, 1, 0, 0); push(EV_AWAIT, 2, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0100, exp_count);
    pulse_start();
    wait_done(3, "t3_frame_done");
    chk("t3_timeout_span", last_done_cyc - last_await_cyc, 10);
    chk("t3_skip_held", int'(skip_mask), 4'b0100);
    repeat (3) @(negedge clk);

    // Empty frame
    source_enable = 4'b0000;
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    pulse_start();
    wait_done(4, "t4_frame_done");
    chk("t4_no_await", await_cnt, 6);
    repeat (3) @(negedge clk);

    // Overrun: start, queued, dropped
    burst_len = '{20, 0, 0, 0};
    source_enable = 4'b0001;
    push(EV_AWAIT, 0, 0, 0);
    push(EV_OVR, 0, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    push(EV_AWAIT, 0, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(6, "t5_two_frames_done");
    chk("t5_frame_count", int'(frame_count), exp_count);
    repeat (3) @(negedge clk);

    // Reset mid-ACTIVE
    burst_len = '{30, 0, 0, 0};
    push(EV_AWAIT, 0, 0, 0);
    pulse_start();
    begin
      int t;
      t = 0;
      while (write_active !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    chk("t6_burst_started", int'(write_active === 1'b1), 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    repeat (40) @(negedge clk);
    chk("t6_no_done_after_reset", done_cnt, 6);
    burst_len = '{4, 0, 0, 0};
    push(EV_AWAIT, 0, 0, 0);
    exp_count++; push(EV_DONE, 0, 4'b0000, exp_count);
    pulse_start();
    wait_done(7, "t6_frame_after_reset");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_write_scheduler.md
Name: frame_write_scheduler

Overview:
- Sequences the frame-buffer write sources (background, sprites, overlays) that share the tri-state write bus and are addressed by write_source_sel.
- On each frame_start it selects every enabled source in ascending ID order and issues a one-cycle write_awaited to it.
- For each source it waits for that source's write_active burst to start and end, then moves to the next source.
- It reports frame completion, the sources that were skipped, and overrun of frame_start requests.

Parameters:
- NUM_SOURCES, 4, number of write sources; source IDs are 0..NUM_SOURCES-1.
- SOURCE_SEL_ADDRW, 2, width of write_source_sel; must satisfy 2**SOURCE_SEL_ADDRW >= NUM_SOURCES.
- START_TIMEOUT, 8, number of cycles to wait for write_active to rise before the current source is skipped.
- FRAME_CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle request to draw one frame.
- source_enable  in  NUM_SOURCES  per-source enable; sampled only when a frame starts.
- write_active  in  1  shared bus line, driven only by the currently selected source.
- write_source_sel  out  SOURCE_SEL_ADDRW  selected source ID; registered.
- write_awaited  out  1  one-cycle start strobe to the selected source; registered.
- busy  out  1  high from frame acceptance through the DONE state.
- frame_done  out  1  one-cycle pulse when all enabled sources have been handled.
- skip_mask  out  NUM_SOURCES  bit k set means source k timed out; valid at frame_done and held until the next frame is accepted.
- frame_overrun  out  1  one-cycle pulse when a frame_start request is dropped.
- frame_count  out  FRAME_CNT_W  number of completed frames; wraps to 0.

Behaviour:
- Reset values: write_source_sel=0, write_awaited=0, busy=0, frame_done=0, skip_mask=0, frame_overrun=0, frame_count=0, state=IDLE, pending=0, timeout counter=0.
- Reset asserted mid-frame aborts immediately; there is no completion pulse.
- All outputs are registered.
- IDLE: on frame_start (or pending=1), latch source_enable into en_q, clear skip_mask and pending, set busy.
  - If en_q has any bit set: go to ISSUE with write_source_sel set to the lowest enabled ID.
  - If en_q is all zero: go to DONE.
- ISSUE (1 cycle): write_awaited=1. Next state is WAIT_START with the counter cleared.
  - Latency: frame_start sampled at edge N gives write_awaited=1 during cycle N+1.
- WAIT_START: write_awaited=0.
  - write_active==1 goes to ACTIVE.
  - Otherwise the counter increments. When the counter reaches START_TIMEOUT-1 with write_active still 0, set skip_mask[sel] and go to ADVANCE.
  - write_active is treated as high only when it reads logic 1; X or Z counts as 0.
- ACTIVE: stay while write_active==1; write_active==0 goes to SETTLE. There is no upper bound on burst length.
- SETTLE (1 cycle): lets the source return to its idle state; then go to ADVANCE.
- ADVANCE (1 cycle):
  - If an enabled ID exists above sel: update write_source_sel to the lowest such ID and go to ISSUE.
  - Otherwise go to DONE.
  - write_source_sel changes only in IDLE and ADVANCE. It is stable from ISSUE through SETTLE.
- DONE (1 cycle): frame_done=1, frame_count increments with wrap.
  - Next state is IDLE. busy drops on the cycle after DONE.
  - If pending=1, that IDLE cycle accepts the queued frame at once.
- frame_start while busy:
  - If pending==0, set pending=1.
  - If pending==1, drop the request and pulse frame_overrun.
- frame_start in the same cycle as DONE counts as busy and sets pending.
- source_enable changes during a frame are ignored.
- write_awaited is never high for two consecutive cycles.

Decomposition:
- Shared frame-manager package/header holds:
  - SOURCE_SEL_ADDRW
  - source ID constants (BKG=0, etc.)
  - the state typedef {IDLE, ISSUE, WAIT_START, ACTIVE, SETTLE, ADVANCE, DONE}
- Sub-module next_source_finder: combinational. Inputs en_q, current sel, and a "from start" flag. Outputs found flag and next ID (lowest enabled ID > sel, or >= 0 when starting).

Test Plan:
- Single source: NUM_SOURCES=4, enable=0001, source 0 model bursts 10 cycles.
  - Expect write_awaited for exactly 1 cycle at sel=0, frame_done 1 cycle after SETTLE+ADVANCE, skip_mask=0000, frame_count=1.
- Ordering: enable=1011, each model bursts 5 cycles.
  - Expect sel sequence 0,1,3; exactly three write_awaited pulses; sel stable during each burst; frame_done once.
- Timeout: enable=0110, source 2 never asserts write_active.
  - Expect source 2 skipped after 8 cycles in WAIT_START, skip_mask=0100, frame_done still pulses.
- Empty frame: enable=0000.
  - Expect frame_done 2 cycles after frame_start, no write_awaited, frame_count=1.
- Overrun: pulse frame_start three times during a busy frame.
  - Expect second pulse queued, third gives frame_overrun=1, exactly 2 frame_done pulses total.
- Reset: assert reset mid-ACTIVE.
  - Expect all outputs 0 asynchronously, no frame_done; after release, a new frame_start runs normally.
